// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
// AXI4-Lite responder backed by a bank of NUM_REGS 32-bit read/write registers.
//
// Ports:
//   ACLK, ARESETn          clock (rising edge) and asynchronous active-low reset
//   S_AXI_AW*, S_AXI_W*    write address / write data channels (independent)
//   S_AXI_B*               write response channel
//   S_AXI_AR*, S_AXI_R*    read address / read data channels
//   reg_out                flattened register contents, reg i at [32*i+31:32*i]
//   reg_wr_pulse           one-cycle pulse on bit i after register i is written
//
// Build option: define AXI_LITE_SLV_DECERR_EN to answer out-of-range accesses
// with DECERR; otherwise they complete with OKAY (writes dropped, reads 0).
//
// state    | meaning
// WR_IDLE  | collecting AW and W (either order); commits once both are held
// WR_RESP  | BVALID high, waiting for BREADY
// RD_IDLE  | ARREADY high, waiting for an AR handshake
// RD_DATA  | RVALID high with RDATA/RRESP held, waiting for RREADY
module axi_lite_slave_regs #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLV_DECERR_EN
    localparam logic [1:0] RESP_OOR = 2'b11;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_DATA } rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:2] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  arready_q, arready_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           regs_q [NUM_REGS];
    logic [31:0]           regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_in_range, rd_in_range;
    logic             unused_addr_lsbs;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;

    assign wr_idx      = awaddr_q[IDX_W+1:2];
    assign wr_in_range = (awaddr_q[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign rd_idx      = S_AXI_ARADDR[IDX_W+1:2];
    assign rd_in_range = (S_AXI_ARADDR[ADDR_WIDTH-1:IDX_W+2] == '0);

    // Byte lanes within a register are selected by WSTRB, not the address.
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    if (wr_in_range) begin
                        for (int k = 0; k < 4; k++) begin
                            if (wstrb_q[k]) begin
                                regs_d[wr_idx][8*k +: 8] = wdata_q[8*k +: 8];
                            end
                        end
                        wr_pulse_d[wr_idx] = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_OOR;
                    end
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_RESP;
                end else begin
                    if (aw_hs) begin
                        awaddr_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                        aw_held_d = 1'b1;
                    end
                    if (w_hs) begin
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                        w_held_d = 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WR_IDLE;
                    bresp_d    = RESP_OKAY;
                end
            end
        endcase
        // Readies look at next-state values so they are valid as registered outputs.
        awready_d = !aw_held_d && (wr_state_d == WR_IDLE);
        wready_d  = !w_held_d && (wr_state_d == WR_IDLE);
    end

    // Reads sample regs_q, so a same-edge write commit returns the pre-write value.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = rd_in_range ? regs_q[rd_idx] : 32'h0;
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_OOR;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    rdata_d    = 32'h0;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = RD_IDLE;
                end
            end
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs_q[g];
    end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder that terminates the AXI4-Lite master interface and backs it with a bank of NUM_REGS 32-bit read/write registers.
- Accepts independent AW/W channels, applies byte strobes, returns B/R responses, and exposes register contents and per-register write strobes to fabric logic.
- Sits opposite axi_lite_master as a synthesizable alternative to the VIP slave in benches and in hardware.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; power of two, 2..256; register i at byte offset 4*i.
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg_out  out  NUM_REGS*32  flattened register contents; register i occupies bits [32*i+31:32*i].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on bit i in the cycle after register i is committed.

Behaviour:
Reset
- All registers, outputs and internal flags clear to 0 while ARESETn=0, including READYs, VALIDs, RDATA, RESP, reg_out and reg_wr_pulse.
- An in-flight transaction is dropped; no response is issued for it after reset releases.
- AWREADY, WREADY and ARREADY first go high on the first ACLK edge after reset deasserts.

Addressing
- Index = addr[log2(NUM_REGS)+1:2]; addr[1:0] is ignored.
- In range when addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] == 0; otherwise out of range.

Write channel (two capture flags aw_held/w_held; states WR_IDLE, WR_RESP)
- AWREADY = !aw_held && !BVALID, registered. WREADY = !w_held && !BVALID, registered.
- An AW handshake latches the address and sets aw_held; a W handshake latches data and strobe and sets w_held.
- AW and W may arrive in either order or in the same cycle.
- On the edge after both flags are set, the write commits:
  - in range: byte k is updated only where WSTRB[k]=1;
  - out of range: no register changes.
- On the commit edge, BVALID goes high, the flags clear, and the state moves to WR_RESP.
- Same-cycle AW+W: the commit occurs 1 cycle after the handshake, and BVALID rises 1 cycle after the handshake.
- BVALID and BRESP hold until BREADY=1. The B handshake returns the state to WR_IDLE, and the READYs go high the next cycle.
- Only one write is outstanding at a time.

Read channel (states RD_IDLE, RD_DATA)
- ARREADY=1 in RD_IDLE.
- An AR handshake registers RDATA = register[index] (0 if out of range) and RRESP, sets RVALID, drops ARREADY, and moves to RD_DATA.
- Latency: RVALID rises on the edge after the AR handshake.
- RDATA, RRESP and RVALID hold until RREADY=1, then the state returns to RD_IDLE with ARREADY=1 the next cycle.
- Only one read is outstanding at a time.

Simultaneous events
- The read and write channels are fully independent.
- A write commit and an AR handshake to the same register on the same edge return the pre-write value.
- reg_wr_pulse[i] fires even when WSTRB=0; it does not fire for out-of-range writes.

Responses
- BRESP/RRESP are OKAY (2'b00) unless the optional feature applies.

Optional Feature:
- Macro AXI_LITE_SLV_DECERR_EN.
- Defined: out-of-range accesses return DECERR (2'b11) on BRESP/RRESP; RDATA=0.
- Undefined: out-of-range accesses return OKAY; writes are silently dropped and reads return 0.
- The handshake timing is identical in both builds.

Test Plan:
- Reset, then same-cycle AW=0x04/W=0xDEADBEEF, WSTRB=0xF, BREADY=1 -> BVALID one cycle after the handshake with BRESP=00; reg_out[63:32]=0xDEADBEEF; reg_wr_pulse=0x02 for one cycle.
- W arrives 3 cycles before AW (addr 0x08, data 0x11223344, WSTRB=0x5) over a register holding 0xAAAAAAAA -> register=0xAA22AA44; WREADY stays low after the W handshake until the B handshake.
- Read addr 0x04 with RREADY held low 4 cycles -> RVALID is stable, RDATA=0xDEADBEEF, ARREADY=0 throughout; ARREADY returns 1 the cycle after the R handshake.
- Write to 0x40 and read from 0x40 with NUM_REGS=8 -> no register changes; RDATA=0; RESP=11 with AXI_LITE_SLV_DECERR_EN, 00 without.
- Write 0x55 to reg 2 committing on the same edge as an AR handshake to 0x08 -> RDATA equals the old value; a following read returns 0x55.
- Assert ARESETn=0 while BVALID=1 and RVALID=1 -> all outputs are 0 immediately; after release, READYs go high and no stale B or R is issued.
